// File: rtl/phy_tx_sched.sv
// Transmit scheduler: round-robin packet arbitration of two AXI-stream sources onto PHY_Tx,
// gated by link-up. Define PHY_TX_SCHED_COMP_EN to add periodic idle/comma compensation gaps.
module phy_tx_sched #(
  parameter int unsigned P_LINKUP_CNT  = 256,
  parameter int unsigned P_COMP_PERIOD = 2048,
  parameter int unsigned P_COMP_LEN    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_ByteAlign,
  input  logic [31:0] i_s0_axis_data,
  input  logic [3:0]  i_s0_axis_keep,
  input  logic        i_s0_axis_valid,
  input  logic        i_s0_axis_last,
  output logic        o_s0_axis_ready,
  input  logic [31:0] i_s1_axis_data,
  input  logic [3:0]  i_s1_axis_keep,
  input  logic        i_s1_axis_valid,
  input  logic        i_s1_axis_last,
  output logic        o_s1_axis_ready,
  output logic [31:0] o_tx_axis_data,
  output logic [3:0]  o_tx_axis_keep,
  output logic        o_tx_axis_valid,
  output logic        o_tx_axis_last,
  input  logic        i_tx_axis_ready,
  output logic        o_link_up,
  output logic [1:0]  o_grant,
  output logic        o_comp_req
);

  localparam int unsigned LinkW = $clog2(P_LINKUP_CNT + 1);
  localparam logic [LinkW-1:0] LinkMax = LinkW'(P_LINKUP_CNT);

  typedef enum logic [2:0] {
    StLinkDown,
    StIdle,
    StGrant0,
    StGrant1,
    StComp,
    StFlush
  } state_e;

  state_e           state_q, state_d;
  logic [LinkW-1:0] link_cnt_q, link_cnt_d;
  logic             rr_q, rr_d;  // last-served source; also the source being flushed
  logic             comp_pend;
  logic             comp_done;
  logic             s0_last_hs, s1_last_hs;
  logic             flush_done;

  // Link-up qualification
  always_comb begin
    link_cnt_d = link_cnt_q;
    if (!i_rx_ByteAlign) begin
      link_cnt_d = '0;
    end else if (link_cnt_q != LinkMax) begin
      link_cnt_d = link_cnt_q + 1'b1;
    end
  end

  assign o_link_up = (link_cnt_q == LinkMax);

  assign s0_last_hs = i_s0_axis_valid & i_tx_axis_ready & i_s0_axis_last;
  assign s1_last_hs = i_s1_axis_valid & i_tx_axis_ready & i_s1_axis_last;
  // Drained source has ready forced high, so its last beat is accepted whenever valid.
  assign flush_done = rr_q ? (i_s1_axis_valid & i_s1_axis_last)
                           : (i_s0_axis_valid & i_s0_axis_last);

`ifdef PHY_TX_SCHED_COMP_EN
  localparam int unsigned PerW = $clog2(P_COMP_PERIOD + 1);
  localparam int unsigned LenW = $clog2(P_COMP_LEN + 1);
  localparam logic [PerW-1:0] PerLast = PerW'(P_COMP_PERIOD - 1);
  localparam logic [LenW-1:0] LenLast = LenW'(P_COMP_LEN - 1);

  logic [PerW-1:0] per_q, per_d;
  logic [LenW-1:0] clen_q, clen_d;
  logic            pend_q, pend_d;

  assign comp_done  = (clen_q == LenLast);
  assign comp_pend  = pend_q;
  assign o_comp_req = (state_q == StComp);

  always_comb begin
    per_d  = per_q;
    pend_d = pend_q;
    clen_d = '0;
    if (state_q == StComp) begin
      clen_d = clen_q + 1'b1;
      if (comp_done) begin
        per_d  = '0;
        pend_d = 1'b0;
        clen_d = '0;
      end
    end else if (state_q != StLinkDown) begin
      if (per_q != PerLast) begin
        per_d = per_q + 1'b1;
      end
      pend_d = pend_q | (per_d == PerLast);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      per_q  <= '0;
      clen_q <= '0;
      pend_q <= 1'b0;
    end else begin
      per_q  <= per_d;
      clen_q <= clen_d;
      pend_q <= pend_d;
    end
  end
`else
  assign comp_pend  = 1'b0;
  assign comp_done  = 1'b0;
  assign o_comp_req = 1'b0;

  // Compensation parameters carry no meaning in this build.
  if (P_COMP_PERIOD == 0 && P_COMP_LEN == 0) begin : g_comp_params_ignored
  end
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StLinkDown;
      link_cnt_q <= '0;
      rr_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      link_cnt_q <= link_cnt_d;
      rr_q       <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      StLinkDown: begin
        if (link_cnt_d == LinkMax) state_d = StIdle;
      end
      StIdle: begin
        if (!i_rx_ByteAlign) begin
          state_d = StLinkDown;
        end else if (comp_pend) begin
          state_d = StComp;
        end else if (i_s0_axis_valid && (!i_s1_axis_valid || rr_q)) begin
          state_d = StGrant0;
          rr_d    = 1'b0;
        end else if (i_s1_axis_valid) begin
          state_d = StGrant1;
          rr_d    = 1'b1;
        end
      end
      StGrant0: begin
        if (s0_last_hs) begin
          state_d = i_rx_ByteAlign ? StIdle : StLinkDown;
        end else if (!i_rx_ByteAlign) begin
          state_d = StFlush;
        end
      end
      StGrant1: begin
        if (s1_last_hs) begin
          state_d = i_rx_ByteAlign ? StIdle : StLinkDown;
        end else if (!i_rx_ByteAlign) begin
          state_d = StFlush;
        end
      end
      StComp: begin
        if (!i_rx_ByteAlign) begin
          state_d = StLinkDown;
        end else if (comp_done) begin
          state_d = StIdle;
        end
      end
      StFlush: begin
        if (flush_done) state_d = StLinkDown;
      end
      default: state_d = StLinkDown;
    endcase
  end

  // Outputs: data path is pure pass-through from the granted source
  always_comb begin
    o_tx_axis_data  = '0;
    o_tx_axis_keep  = '0;
    o_tx_axis_valid = 1'b0;
    o_tx_axis_last  = 1'b0;
    o_s0_axis_ready = 1'b0;
    o_s1_axis_ready = 1'b0;
    o_grant         = 2'b00;
    case (state_q)
      StGrant0: begin
        o_tx_axis_data  = i_s0_axis_data;
        o_tx_axis_keep  = i_s0_axis_keep;
        o_tx_axis_valid = i_s0_axis_valid;
        o_tx_axis_last  = i_s0_axis_last;
        o_s0_axis_ready = i_tx_axis_ready;
        o_grant         = 2'b01;
      end
      StGrant1: begin
        o_tx_axis_data  = i_s1_axis_data;
        o_tx_axis_keep  = i_s1_axis_keep;
        o_tx_axis_valid = i_s1_axis_valid;
        o_tx_axis_last  = i_s1_axis_last;
        o_s1_axis_ready = i_tx_axis_ready;
        o_grant         = 2'b10;
      end
      StFlush: begin
        if (rr_q) o_s1_axis_ready = 1'b1;
        else      o_s0_axis_ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
